sysx_transfer_sequencer: RTL and testbench
==========================================

# sysx_transfer_sequencer

Sequencer that drives word transfers on the sysX master's 8-bit serial-parallel bus. It walks the MOSI buffer one 32-bit word at a time, shifts each word out as four bytes under a programmable bus clock, assembles the returned MISO bytes into words, and writes them back into the MISO buffer. It sits between the sysX master's register file and buffers and the external bus pins, and replaces the master's inline pipeline state machine.

## Interface
Parameters:
- ADDR_W, 8, buffer address width; also the word-index width.
- DIV_W, 12, bus-clock divider width.

Ports:
- iClk  in  1  system clock; the only clock in the block.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse that requests a transfer; sampled only in IDLE.
- iWordCount  in  ADDR_W  number of words to transfer; 0 means 2^ADDR_W.
- iDivider  in  DIV_W  bus-clock half-period, expressed as (iClk cycles − 1).
- iSelect  in  2  target device for the transfer; 0 is invalid.
- iIntAck  in  1  clears the pending completion interrupt.
- oBusy  out  1  high from the cycle after an accepted start until oDone.
- oDone  out  1  one-cycle completion pulse.
- oMosiAddr  out  ADDR_W  MOSI buffer read address.
- iMosiData  in  32  MOSI buffer read data; valid 1 cycle after the address.
- oMisoAddr  out  ADDR_W  MISO buffer write address.
- oMisoData  out  32  assembled MISO word.
- oMisoWrite  out  1  one-cycle MISO buffer write strobe.
- oBusMOSI  out  8  outgoing byte.
- iBusMISO  in  8  incoming byte.
- oBusClock  out  1  bus clock.
- oBusSelect  out  2  device select; 0 means no device selected.
- iBusInterrupt  in  1  asynchronous device interrupt.
- oInterrupt  out  1  pending completion OR synchronized iBusInterrupt.

## Operation
- States are IDLE, LOAD, LATCH, BYTE3, BYTE2, BYTE1, BYTE0, STORE.
- IDLE: on iStart with iSelect≠0, the block latches iWordCount, iDivider and iSelect, clears the word index to 0, and moves to LOAD. An iStart with iSelect=0 is ignored; no state change and no oDone.
- LOAD (1 cycle): oMosiAddr = index.
- LATCH (1 cycle): iMosiData is captured into the shift register.
- BYTEn: oBusMOSI = shift[8n+7:8n], most significant byte first.
  - The tick counter runs from 0 to the latched divider; each terminal count is one tick.
  - First tick: oBusClock rises, and iBusMISO is sampled into byte n of the receive register on that same edge.
  - Second tick: oBusClock falls and the state advances to the next byte.
- STORE (1 cycle): oMisoWrite=1, oMisoAddr=index, oMisoData=receive register.
  - If index+1 equals the latched count (compared modulo 2^ADDR_W; count 0 means 2^ADDR_W), go to IDLE and assert oDone on the next cycle.
  - Otherwise increment the index and go to LOAD.
- oBusSelect holds the latched select from LOAD through STORE, and is 0 in IDLE.
- oBusClock is 0 outside the BYTE states.
- Completion sets an interrupt-pending flag. iIntAck clears it; if iIntAck and completion occur in the same cycle, set wins. An accepted iStart also clears the flag.
- iBusInterrupt passes through a 2-flop synchronizer and is ORed into oInterrupt.
- A start request while busy is ignored.
- The divider is latched at start, so changes to iDivider mid-transfer have no effect.

## Timing
- Reset values: all outputs 0, state IDLE, index 0, pending flag clear, synchronizer flops 0.
- A reset mid-transfer aborts in the same cycle. There is no MISO write and no oDone, and oBusSelect and oBusClock drop on the next edge.
- Per word: 2 + 8·(D+1) + 1 cycles, where D is the latched divider.
- Taking the iStart sample as cycle 0: LOAD is cycle 1, and oDone is high in cycle 3 + N·(3 + 8(D+1)) − 2 for N words.
  - With N=1 and D=0, oDone is in cycle 12.
- oBusy rises in cycle 1 and falls in the same cycle that oDone is high.
- The MISO sample for a byte is taken on the iClk edge that drives oBusClock high.
- oBusMOSI is stable for the full byte phase.

## Structure
- A shared package, sysx_pkg, holds:
  - the state encoding localparams (3-bit);
  - the byte-lane constants;
  - SYSX_SEL_NONE = 2'd0.
- One sub-module, sysx_clock_tick, contains the DIV_W counter. It has inputs enable and divider, and outputs a tick pulse. The counter resets to 0 whenever enable is low.
- Everything else, including the FSM, shift register, index and interrupt logic, lives in the top module.

## Test plan
- N=1, D=0, MOSI[0]=0x11223344, device returns AA,BB,CC,DD -> oBusMOSI sequence 11,22,33,44; one MISO write of 0xAABBCCDD at address 0; oDone in cycle 12.
- N=3, D=2, select=2 -> writes at addresses 0,1,2; each oBusClock high and low phase lasts 3 cycles; oBusSelect=2 throughout; oDone in cycle 3+3·27−2=82.
- iWordCount=0 -> 256 words transferred; index wraps 255→0 only at completion; exactly 256 writes.
- iStart with iSelect=0, then iStart during a busy transfer -> both ignored; no extra writes and a single oDone.
- iReset asserted during BYTE1 of word 0 -> no MISO write and no oDone; all outputs 0 the next cycle; a fresh start then runs normally.
- Completion with iIntAck in the same cycle -> oInterrupt stays high. iBusInterrupt pulse -> oInterrupt rises 2 cycles later.

Source files
------------

// File: rtl/sysx_pkg.sv
// sysx_pkg: shared types and constants for the sysX transfer sequencer.
// Holds the FSM encoding, byte-lane constants and a byte-select helper.
package sysx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_BYTE3 = 3'd3;
  localparam logic [2:0] ST_BYTE2 = 3'd4;
  localparam logic [2:0] ST_BYTE1 = 3'd5;
  localparam logic [2:0] ST_BYTE0 = 3'd6;
  localparam logic [2:0] ST_STORE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_LATCH = ST_LATCH,
    S_BYTE3 = ST_BYTE3,
    S_BYTE2 = ST_BYTE2,
    S_BYTE1 = ST_BYTE1,
    S_BYTE0 = ST_BYTE0,
    S_STORE = ST_STORE
  } sysx_state_e;

  localparam logic [1:0] LANE3 = 2'd3;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE0 = 2'd0;

  localparam logic [1:0] SYSX_SEL_NONE = 2'd0;

  function automatic logic [7:0] lane_byte(
    input logic [31:0] w,
    input logic [1:0]  lane
  );
    return w[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [1:0] state_lane(input sysx_state_e s);
    unique case (s)
      S_BYTE3: return LANE3;
      S_BYTE2: return LANE2;
      S_BYTE1: return LANE1;
      default: return LANE0;
    endcase
  endfunction

endpackage

// File: rtl/sysx_transfer_sequencer_if.sv
// sysx_transfer_sequencer_if: buffer and external bus signals.
// master = sequencer side, slave = buffers/pins side.
interface sysx_transfer_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] oMosiAddr;
  logic [31:0]       iMosiData;
  logic [ADDR_W-1:0] oMisoAddr;
  logic [31:0]       oMisoData;
  logic              oMisoWrite;
  logic [7:0]        oBusMOSI;
  logic [7:0]        iBusMISO;
  logic              oBusClock;
  logic [1:0]        oBusSelect;
  logic              iBusInterrupt;

  modport master (
    output oMosiAddr, oMisoAddr, oMisoData, oMisoWrite,
    output oBusMOSI, oBusClock, oBusSelect,
    input  iMosiData, iBusMISO, iBusInterrupt
  );

  modport slave (
    input  oMosiAddr, oMisoAddr, oMisoData, oMisoWrite,
    input  oBusMOSI, oBusClock, oBusSelect,
    output iMosiData, iBusMISO, iBusInterrupt
  );
endinterface

// File: rtl/sysx_clock_tick.sv
// sysx_clock_tick: bus-clock divider; tick on terminal count.
// Ports: iClk, iReset, enable, divider (terminal count), tick.
module sysx_clock_tick #(
  parameter int DIV_W = 12
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == divider);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable || tick) cnt_d = '0;
  end

  always_ff @(posedge iClk) begin
    if (iReset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sysx_transfer_sequencer.sv
// sysx_transfer_sequencer: walks MOSI buffer, shifts words out as bytes,
// writes assembled MISO words back. Ports: control (start/count/divider/
// select/ack, busy/done/interrupt) plus bus interface (buffers + pins).
module sysx_transfer_sequencer
  import sysx_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 12
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iWordCount,
  input  logic [DIV_W-1:0]  iDivider,
  input  logic [1:0]        iSelect,
  input  logic              iIntAck,
  output logic              oBusy,
  output logic              oDone,
  output logic              oInterrupt,
  sysx_transfer_sequencer_if.master bus
);

  sysx_state_e       state_q;
  logic [ADDR_W-1:0] idx_q, wcnt_q, maddr_q, waddr_q;
  logic [ADDR_W-1:0] idx_nxt;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        sel_q;
  logic [31:0]       shift_q, rx_q, wdata_q;
  logic [7:0]        mosi_q;
  logic              clk_q, wr_q, busy_q, done_q;
  logic              pend_q, pend_d;
  logic              s1_q, s2_q;
  logic              tick, in_byte, start_ok, last;
  logic [1:0]        lane;

  assign in_byte = (state_q == S_BYTE3) || (state_q == S_BYTE2) ||
                   (state_q == S_BYTE1) || (state_q == S_BYTE0);
  assign lane     = state_lane(state_q);
  assign idx_nxt  = idx_q + 1'b1;
  // count 0 wraps to 0 after 2^ADDR_W words
  assign last     = (state_q == S_STORE) && (idx_nxt == wcnt_q);
  assign start_ok = (state_q == S_IDLE) && iStart &&
                    (iSelect != SYSX_SEL_NONE);

  sysx_clock_tick #(.DIV_W(DIV_W)) u_tick (
    .iClk    (iClk),
    .iReset  (iReset),
    .enable  (in_byte),
    .divider (div_q),
    .tick    (tick)
  );

  // Pending holds through the done pulse too, so an ack landing on
  // either the final STORE or the done cycle loses to the set.
  always_comb begin
    pend_d = pend_q;
    if (iIntAck)         pend_d = 1'b0;
    if (last || done_q)  pend_d = 1'b1;
    if (start_ok)        pend_d = 1'b0;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      maddr_q <= '0;
      waddr_q <= '0;
      div_q   <= '0;
      sel_q   <= SYSX_SEL_NONE;
      shift_q <= '0;
      rx_q    <= '0;
      wdata_q <= '0;
      mosi_q  <= '0;
      clk_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      pend_q <= pend_d;
      s1_q   <= bus.iBusInterrupt;
      s2_q   <= s1_q;
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            wcnt_q  <= iWordCount;
            div_q   <= iDivider;
            sel_q   <= iSelect;
            idx_q   <= '0;
            maddr_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: state_q <= S_LATCH;
        S_LATCH: begin
          shift_q <= bus.iMosiData;
          mosi_q  <= lane_byte(bus.iMosiData, LANE3);
          state_q <= S_BYTE3;
        end
        S_BYTE3, S_BYTE2, S_BYTE1, S_BYTE0: begin
          if (tick) begin
            if (!clk_q) begin
              clk_q <= 1'b1;
              rx_q[{lane, 3'b000} +: 8] <= bus.iBusMISO;
            end else begin
              clk_q <= 1'b0;
              if (state_q == S_BYTE0) begin
                mosi_q  <= '0;
                wr_q    <= 1'b1;
                waddr_q <= idx_q;
                wdata_q <= rx_q;
                state_q <= S_STORE;
              end else begin
                mosi_q  <= lane_byte(shift_q, lane - 2'd1);
                state_q <= sysx_state_e'(state_q + 3'd1);
              end
            end
          end
        end
        S_STORE: begin
          idx_q <= idx_nxt;
          if (last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            sel_q   <= SYSX_SEL_NONE;
            state_q <= S_IDLE;
          end else begin
            maddr_q <= idx_nxt;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oBusy          = busy_q;
  assign oDone          = done_q;
  assign oInterrupt     = pend_q | s2_q;
  assign bus.oMosiAddr  = maddr_q;
  assign bus.oMisoAddr  = waddr_q;
  assign bus.oMisoData  = wdata_q;
  assign bus.oMisoWrite = wr_q;
  assign bus.oBusMOSI   = mosi_q;
  assign bus.oBusClock  = clk_q;
  assign bus.oBusSelect = sel_q;

endmodule

// File: tb/tb_sysx_transfer_sequencer.sv
// tb_sysx_transfer_sequencer: directed bench with a cycle-exact model
// of the transfer timeline and immediate assertions per check.
module tb_sysx_transfer_sequencer;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iStart;
  logic [7:0]  iWordCount;
  logic [11:0] iDivider;
  logic [1:0]  iSelect;
  logic        iIntAck;
  logic        oBusy, oDone, oInterrupt;

  int nvec = 0;
  int nerr = 0;

  sysx_transfer_sequencer_if #(.ADDR_W(8)) bus ();

  sysx_transfer_sequencer #(.ADDR_W(8), .DIV_W(12)) dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iStart     (iStart),
    .iWordCount (iWordCount),
    .iDivider   (iDivider),
    .iSelect    (iSelect),
    .iIntAck    (iIntAck),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oInterrupt (oInterrupt),
    .bus        (bus)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] mosi_word(input int w);
    logic [7:0] b;
    b = 8'(w);
    return 32'h11223344 ^ {4{b}};
  endfunction

  function automatic logic [31:0] miso_word(input int w);
    logic [7:0] b;
    b = 8'(w);
    return 32'hAABBCCDD ^ {4{b}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // n = iWordCount (0 -> 256 words); stop_c > 0 ends early after that
  // cycle; poke_c issues a start while busy; ack_c pulses iIntAck.
  task automatic run_xfer(input int n, input int d, input logic [1:0] sel,
                          input int stop_c, input int poke_c,
                          input int ack_c);
    int nw, per, last_c, end_c, nwr;
    int p, w, q, r, lane;
    logic busy, inb;
    logic [31:0] mw, sw;
    nw     = (n == 0) ? 256 : n;
    per    = 3 + 8 * (d + 1);
    last_c = nw * per;
    end_c  = (stop_c > 0) ? stop_c : last_c + 2;
    nwr    = 0;
    iWordCount = 8'(n);
    iDivider   = 12'(d);
    iSelect    = sel;
    iStart     = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    for (int c = 1; c <= end_c; c++) begin
      busy = (c <= last_c);
      p    = (c - 1) % per;
      w    = (c - 1) / per;
      inb  = busy && (p >= 2) && (p < per - 1);
      q    = p - 2;
      r    = inb ? q % (2 * (d + 1)) : 0;
      lane = inb ? 3 - q / (2 * (d + 1)) : 0;
      mw   = mosi_word(w);
      sw   = miso_word(w);
      chk("busy", oBusy, busy);
      chk("done", oDone, c == last_c + 1);
      chk("select", bus.oBusSelect, busy ? sel : 2'd0);
      chk("busclk", bus.oBusClock, inb && (r > d));
      chk("irq", oInterrupt, c > last_c);
      chk("miso_wr", bus.oMisoWrite, busy && (p == per - 1));
      if (inb) chk("mosi_byte", bus.oBusMOSI, mw[8*lane +: 8]);
      if (busy && p == 0) chk("mosi_addr", bus.oMosiAddr, w[7:0]);
      if (busy && p == per - 1) begin
        chk("miso_addr", bus.oMisoAddr, w[7:0]);
        chk("miso_data", bus.oMisoData, sw);
      end
      if (bus.oMisoWrite === 1'b1) nwr++;
      bus.iMosiData = (busy && p == 1) ? mw : 32'hDEADBEEF;
      if (inb) bus.iBusMISO = (r == d) ? sw[8*lane +: 8]
                                       : ~sw[8*lane +: 8];
      else     bus.iBusMISO = 8'h5A;
      iStart  = (c == poke_c);
      if (c == poke_c) begin
        iDivider   = 12'd7;
        iWordCount = 8'd9;
        iSelect    = 2'd3;
      end
      iIntAck = (c == ack_c);
      if (c < end_c) @(negedge iClk);
    end
    if (stop_c == 0) chk("write_count", nwr, nw);
    iStart  = 1'b0;
    iIntAck = 1'b0;
  endtask

  initial begin
    iReset = 1'b1;
    iStart = 1'b0;
    iWordCount = '0;
    iDivider = '0;
    iSelect = '0;
    iIntAck = 1'b0;
    bus.iMosiData = 32'hDEADBEEF;
    bus.iBusMISO = 8'h5A;
    bus.iBusInterrupt = 1'b0;
    repeat (3) @(negedge iClk);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_irq", oInterrupt, 1'b0);
    chk("rst_sel", bus.oBusSelect, 2'd0);
    chk("rst_clk", bus.oBusClock, 1'b0);
    chk("rst_wr", bus.oMisoWrite, 1'b0);
    chk("rst_mosi", bus.oBusMOSI, 8'h00);
    chk("rst_maddr", bus.oMosiAddr, 8'h00);
    chk("rst_wdata", bus.oMisoData, 32'h0);
    iReset = 1'b0;
    @(negedge iClk);

    // single word, D=0: done in cycle 12
    run_xfer(1, 0, 2'd1, 0, 0, 0);
    iIntAck = 1'b1;
    @(negedge iClk);
    iIntAck = 1'b0;
    chk("ack_clear", oInterrupt, 1'b0);

    // three words, D=2, busy start + divider change, ack on last STORE
    run_xfer(3, 2, 2'd2, 0, 10, 81);

    // start with select 0 is ignored; pending interrupt untouched
    iSelect = 2'd0;
    iWordCount = 8'd1;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      chk("sel0_busy", oBusy, 1'b0);
      chk("sel0_done", oDone, 1'b0);
      chk("sel0_bsel", bus.oBusSelect, 2'd0);
      chk("sel0_irq", oInterrupt, 1'b1);
    end
    iIntAck = 1'b1;
    @(negedge iClk);
    iIntAck = 1'b0;
    chk("ack2_clear", oInterrupt, 1'b0);

    // bus interrupt through the synchronizer
    bus.iBusInterrupt = 1'b1;
    @(negedge iClk);
    bus.iBusInterrupt = 1'b0;
    chk("bint_k1", oInterrupt, 1'b0);
    @(negedge iClk);
    chk("bint_k2", oInterrupt, 1'b1);
    @(negedge iClk);
    chk("bint_k3", oInterrupt, 1'b0);

    // reset during BYTE1 of word 0
    run_xfer(1, 0, 2'd1, 7, 0, 0);
    iReset = 1'b1;
    @(negedge iClk);
    iReset = 1'b0;
    chk("abort_busy", oBusy, 1'b0);
    chk("abort_done", oDone, 1'b0);
    chk("abort_sel", bus.oBusSelect, 2'd0);
    chk("abort_clk", bus.oBusClock, 1'b0);
    chk("abort_mosi", bus.oBusMOSI, 8'h00);
    chk("abort_wr", bus.oMisoWrite, 1'b0);
    chk("abort_irq", oInterrupt, 1'b0);
    chk("abort_waddr", bus.oMisoAddr, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      chk("post_abort_wr", bus.oMisoWrite, 1'b0);
      chk("post_abort_done", oDone, 1'b0);
    end
    run_xfer(2, 1, 2'd2, 0, 0, 0);

    // count 0 -> 256 words
    run_xfer(0, 0, 2'd3, 0, 0, 0);

    // ack in the done cycle loses to the completion set
    run_xfer(1, 0, 2'd1, 0, 0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
